// File: rtl/modexp_pkg.sv
// Shared types for the Montgomery-ladder exponentiation engine.
// FSM states, multiplier operand-select encodings, default width.
package modexp_pkg;

  localparam int DEF_WIDTH = 1024;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SCAN,
    ST_TO,
    ST_TO_W,
    ST_STEP,
    ST_STEP_W,
    ST_FROM,
    ST_FROM_W,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    OPA_X_R2,
    OPA_R0_R1,
    OPA_R0_ONE
  } opa_e;

  typedef enum logic {
    OPB_R1_R1,
    OPB_R0_R0
  } opb_e;

endpackage

// File: rtl/mont_mul.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod m.
// Latency WIDTH+1+XLAT cycles from the start cycle to the done pulse.
module mont_mul
  import modexp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int XLAT  = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int TW = WIDTH + 2;
  localparam int IW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q, b_q, m_q;
  logic [TW-1:0]    t, s, s2, t_nx, mx;
  logic [WIDTH-1:0] red;
  logic [IW-1:0]    i;
  logic             run, done_i;

  // t stays below 2m, so one conditional subtract finishes the reduction
  always_comb begin
    mx   = {2'b00, m_q};
    s    = t + (a_q[0] ? {2'b00, b_q} : '0);
    s2   = s[0] ? s + mx : s;
    t_nx = s2 >> 1;
    red  = (t_nx >= mx) ? WIDTH'(t_nx - mx) : WIDTH'(t_nx);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      t      <= '0;
      i      <= '0;
      run    <= 1'b0;
      done_i <= 1'b0;
      result <= '0;
    end else begin
      done_i <= 1'b0;
      if (start) begin
        a_q <= a;
        b_q <= b;
        m_q <= m;
        t   <= '0;
        i   <= IW'(WIDTH);
        run <= 1'b1;
      end else if (run) begin
        t   <= t_nx;
        a_q <= a_q >> 1;
        i   <= i - IW'(1);
        if (i == IW'(1)) begin
          run    <= 1'b0;
          result <= red;
          done_i <= 1'b1;
        end
      end
    end
  end

  generate
    if (XLAT == 0) begin : g_nodly
      assign done = done_i;
    end else begin : g_dly
      logic [XLAT-1:0] pipe;
      logic [XLAT:0]   nx;
      assign nx   = {pipe, done_i};
      assign done = pipe[XLAT-1];
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) pipe <= '0;
        else         pipe <= nx[XLAT-1:0];
      end
    end
  endgenerate

endmodule

// File: rtl/modexp_ladder_p.sv
// Montgomery-ladder x^e mod m controller driving two mont_mul cores.
// Leading exponent zeros are skipped before the ladder starts.
module modexp_ladder_p
  import modexp_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int EXPW   = WIDTH,
  parameter int CNTW   = $clog2(EXPW + 1),
  parameter int B_XLAT = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_m,
  input  logic [EXPW-1:0]  in_e,
  input  logic [WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0] in_r2,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state;
  logic [WIDTH-1:0] r0, r1, xr, mr, r2r;
  logic [EXPW-1:0]  e_q;
  logic [CNTW-1:0]  cnt;
  logic             fa, fb, both, bit_b;
  opa_e             opa;
  opb_e             opb;
  logic             a_start, b_start, a_done, b_done;
  logic [WIDTH-1:0] a_a, a_b, b_a, b_b, a_res, b_res;

  assign bit_b   = e_q[EXPW-1];
  assign result  = r0;
  assign a_start = (state == ST_TO) || (state == ST_STEP) ||
                   (state == ST_FROM);
  assign b_start = (state == ST_STEP);
  assign both    = (fa | a_done) & (fb | b_done);

  always_comb begin
    opa = OPA_R0_R1;
    if (state == ST_TO)   opa = OPA_X_R2;
    if (state == ST_FROM) opa = OPA_R0_ONE;
    opb = bit_b ? OPB_R1_R1 : OPB_R0_R0;
  end

  always_comb begin
    a_a = r0;
    a_b = r1;
    unique case (1'b1)
      (opa == OPA_X_R2): begin
        a_a = xr;
        a_b = r2r;
      end
      (opa == OPA_R0_ONE): begin
        a_a = r0;
        a_b = ONE;
      end
      default: ;
    endcase
    b_a = (opb == OPB_R1_R1) ? r1 : r0;
    b_b = b_a;
  end

  mont_mul #(.WIDTH(WIDTH), .XLAT(0)) u_mul_a (
    .clk    (clk),
    .resetn (resetn),
    .start  (a_start),
    .a      (a_a),
    .b      (a_b),
    .m      (mr),
    .result (a_res),
    .done   (a_done)
  );

  mont_mul #(.WIDTH(WIDTH), .XLAT(B_XLAT)) u_mul_b (
    .clk    (clk),
    .resetn (resetn),
    .start  (b_start),
    .a      (b_a),
    .b      (b_b),
    .m      (mr),
    .result (b_res),
    .done   (b_done)
  );

  // Sticky completion flags: the two cores may finish in either order
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fa <= 1'b0;
      fb <= 1'b0;
    end else if (state == ST_STEP_W) begin
      if (both) begin
        fa <= 1'b0;
        fb <= 1'b0;
      end else begin
        fa <= fa | a_done;
        fb <= fb | b_done;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      r0    <= '0;
      r1    <= '0;
      xr    <= '0;
      mr    <= '0;
      r2r   <= '0;
      e_q   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          e_q   <= in_e;
          r0    <= in_r;
          xr    <= in_x;
          mr    <= in_m;
          r2r   <= in_r2;
          cnt   <= CNTW'(EXPW);
          busy  <= 1'b1;
          state <= ST_SCAN;
        end
        ST_SCAN: begin
          if (cnt == '0) begin
            state <= ST_FROM;
          end else if (bit_b) begin
            state <= ST_TO;
          end else begin
            e_q <= e_q << 1;
            cnt <= cnt - CNTW'(1);
          end
        end
        ST_TO: state <= ST_TO_W;
        ST_TO_W: if (a_done) begin
          r1    <= a_res;
          state <= ST_STEP;
        end
        ST_STEP: state <= ST_STEP_W;
        ST_STEP_W: if (both) begin
          if (bit_b) begin
            r0 <= a_res;
            r1 <= b_res;
          end else begin
            r1 <= a_res;
            r0 <= b_res;
          end
          e_q   <= e_q << 1;
          cnt   <= cnt - CNTW'(1);
          state <= (cnt == CNTW'(1)) ? ST_FROM : ST_STEP;
        end
        ST_FROM: state <= ST_FROM_W;
        ST_FROM_W: if (a_done) begin
          r0    <= a_res;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ladder_p.sv
// Directed bench for modexp_ladder_p at WIDTH=8, m=239.
// Multiplier B carries extra done latency relative to A.
module tb_modexp_ladder_p;
  import modexp_pkg::*;

  localparam int W  = 8;
  localparam int EW = 8;
  localparam int XL = 3;
  localparam int LA = W + 1;
  localparam int LB = LA + XL;

  logic          clk, resetn, start, busy, done;
  logic [W-1:0]  in_x, in_m, in_r, in_r2, result;
  logic [EW-1:0] in_e;

  int checks = 0;
  int errors = 0;

  modexp_ladder_p #(.WIDTH(W), .EXPW(EW), .B_XLAT(XL)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .in_x   (in_x),
    .in_m   (in_m),
    .in_e   (in_e),
    .in_r   (in_r),
    .in_r2  (in_r2),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  x;
    logic [EW-1:0] e;
    logic [W-1:0]  res;
    string         nm;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int bitlen(input logic [EW-1:0] e);
    int k = 0;
    for (int i = 0; i < EW; i++) if (e[i]) k = i + 1;
    return k;
  endfunction

  function automatic int exp_cycles(input logic [EW-1:0] e);
    int k = bitlen(e);
    int z = EW - k;
    if (e == '0) return 1 + (EW + 1) + (LA + 1);
    return 1 + (z + 1) + (LA + 1) + k * (LB + 1) + (LA + 1);
  endfunction

  task automatic set_ops();
    in_m  = 8'd239;
    in_r  = 8'd17;
    in_r2 = 8'd50;
  endtask

  // mode 0: plain run; 1: extra start pulse in STEP_W; 2: reset in STEP_W
  task automatic run(input logic [W-1:0] x, input logic [EW-1:0] e,
                     input logic [W-1:0] exp_res, input string nm,
                     input int mode);
    int n, steps, busy_bad;
    bit injected;
    logic [W-1:0] held;
    @(negedge clk);
    set_ops();
    in_x  = x;
    in_e  = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_x  = 8'($urandom);
    in_e  = 8'($urandom);
    in_m  = 8'($urandom);
    in_r  = 8'($urandom);
    in_r2 = 8'($urandom);
    n = 1;
    steps = 0;
    busy_bad = 0;
    injected = 1'b0;
    while (done !== 1'b1 && n < 3000) begin
      if (dut.state == ST_STEP) steps++;
      if (busy !== 1'b1) busy_bad++;
      start = 1'b0;
      if (mode == 1 && !injected && dut.state == ST_STEP_W) begin
        start = 1'b1;
        in_x  = 8'd9;
        in_e  = 8'd77;
        injected = 1'b1;
      end
      if (mode == 2 && dut.state == ST_STEP_W) begin
        resetn = 1'b0;
        #1;
        chk({nm, "_abort_busy"}, busy, 0);
        chk({nm, "_abort_done"}, done, 0);
        chk({nm, "_abort_res"}, result, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk({nm, "_abort_idle"}, (dut.state == ST_IDLE), 1);
        chk({nm, "_abort_nodone"}, done, 0);
        return;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, done, 1);
    chk({nm, "_result"}, result, exp_res);
    chk({nm, "_cycles"}, n, exp_cycles(e));
    chk({nm, "_busy"}, busy_bad, 0);
    chk({nm, "_iters"}, steps, bitlen(e));
    if (mode == 1) chk({nm, "_injected"}, injected, 1);
    held = result;
    @(negedge clk);
    chk({nm, "_done_pulse"}, done, 0);
    chk({nm, "_held"}, result, exp_res);
    chk({nm, "_held_eq"}, result, held);
  endtask

  initial begin
    tv[0] = '{8'd5,   8'd3,   8'd125, "x5e3"};
    tv[1] = '{8'd2,   8'd10,  8'd68,  "x2e10"};
    tv[2] = '{8'd77,  8'd0,   8'd1,   "x77e0"};
    tv[3] = '{8'd238, 8'd255, 8'd238, "x238e255"};
    tv[4] = '{8'd3,   8'd5,   8'd4,   "x3e5"};
    tv[5] = '{8'd10,  8'd2,   8'd100, "x10e2"};
    tv[6] = '{8'd2,   8'd8,   8'd17,  "x2e8"};
    tv[7] = '{8'd0,   8'd7,   8'd0,   "x0e7"};
    tv[8] = '{8'd5,   8'd1,   8'd5,   "x5e1"};
    tv[9] = '{8'd1,   8'd200, 8'd1,   "x1e200"};

    resetn = 1'b0;
    start  = 1'b0;
    in_x   = '0;
    in_e   = '0;
    set_ops();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_idle", (dut.state == ST_IDLE), 1);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++)
      run(tv[i].x, tv[i].e, tv[i].res, tv[i].nm, 0);

    run(8'd5, 8'd3, 8'd125, "restart_ign", 1);
    run(8'd238, 8'd255, 8'd238, "abort", 2);
    run(8'd5, 8'd3, 8'd125, "post_abort", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modexp_ladder_p.md
# modexp_ladder_p

Parametrised Montgomery-ladder modular exponentiation engine computing result = x^e mod m for WIDTH-bit operands. It supersedes the fixed 1024-bit ladder controller and adds:
- an internal exponent scan that skips leading zeros, so no external exponent-length input is needed;
- a busy/done handshake;
- asynchronous reset.

It sits between the RSA top-level and two instances of the Montgomery multiplier core.

## Interface
Parameters:
- WIDTH, 1024: operand/modulus width in bits.
- EXPW, WIDTH: exponent width in bits.
- CNTW, $clog2(EXPW+1): bit-counter width (derived; do not override).

Ports:
- clk  in  1  clock. One clock domain; all state changes on the rising edge.
- resetn  in  1  reset. Asynchronous assertion, active low.
- start  in  1  one-cycle request. Sampled only in IDLE.
- in_x  in  WIDTH  base, x < m.
- in_m  in  WIDTH  modulus, odd.
- in_e  in  EXPW  exponent.
- in_r  in  WIDTH  R mod m, where R = 2^WIDTH.
- in_r2  in  WIDTH  R^2 mod m.
- result  out  WIDTH  x^e mod m. Valid from the done pulse until the next accepted start.
- busy  out  1  high from the cycle after start is accepted until the cycle done pulses.
- done  out  1  one-cycle completion pulse.

## Operation
Inputs are captured into internal registers on the accepted start. Ports may change afterwards.

Montgomery multiplication is written mont(a,b) = a·b·R⁻¹ mod m. Registers: R0, R1, E (EXPW bits), bit counter cnt.

States and transitions:
- IDLE:
  - On start: E←in_e, R0←in_r, cnt←EXPW → SCAN.
- SCAN, one bit per cycle:
  - If cnt==0, then e=0 → FROM.
  - Else if E[EXPW-1]==1 → TO.
  - Else shift E left by 1, decrement cnt, stay in SCAN.
- TO:
  - Pulse start on mult A with (in_x, in_r2) → TO_W.
- TO_W:
  - On A.done: R1←A.result → STEP.
- STEP:
  - Let b = E[EXPW-1].
  - b=1: A computes mont(R0,R1), B computes mont(R1,R1).
  - b=0: A computes mont(R0,R1), B computes mont(R0,R0).
  - Pulse both starts → STEP_W.
- STEP_W:
  - Latch each multiplier's done into a sticky flag.
  - When both flags are set, write results:
    - b=1: R0←A, R1←B.
    - b=0: R1←A, R0←B.
  - Clear the flags, shift E, decrement cnt.
  - If cnt becomes 0 → FROM, else → STEP.
- FROM:
  - Pulse A with (R0, 1) → FROM_W.
- FROM_W:
  - On A.done: R0←A.result → DONE.
- DONE:
  - done=1 for one cycle, result = R0 → IDLE.

Rules:
- b is sampled in STEP and held stable through STEP_W. E is not shifted until the write.
- e=0 gives result = mont(R mod m, 1) = 1.
- The ladder never processes leading zeros, so ladder iterations = bit-length of e.
- start outside IDLE is ignored, with no effect on the running operation.
- result is driven by R0 and is held after DONE. It changes only after the next accepted start.

## Timing
- Reset values: busy=0, done=0, state=IDLE, flags=0, result=0 (R0 cleared).
- Resetn low mid-operation aborts immediately:
  - Multipliers receive the same reset.
  - No done pulse is produced.
  - After release, the block is in IDLE.
- Multiplier latency L: done pulses L cycles after its start cycle, where L ≥ 1. L may differ between A and B and between calls.
- With constant L, with z leading zeros and k = bit-length of e, the done pulse occurs 1 + (z+1) + (L+1) + k(L+1) + (L+1) cycles after the start cycle.
- Special case e=0: the done pulse occurs 1 + (EXPW+1) + (L+1) cycles after the start cycle.
- A new start is accepted in the cycle immediately after done.

## Structure
- Shared package modexp_pkg holds:
  - state enum ST_IDLE … ST_DONE;
  - the encoding of the operand-select muxes;
  - the default-width constant.
- Sub-module: two instances of mont_mul #(WIDTH).
  - Ports: clk, resetn, start, a, b, m, result, done.
  - done is a one-cycle pulse.
- The sticky done-flag pair is a small in-file always block, not a separate module.

## Test plan
WIDTH=8, EXPW=8, m=239, in_r=17, in_r2=50 throughout.
- x=5, e=3 → done pulse with result=125. Check busy high across the run. Check the ladder executes exactly 2 iterations.
- x=2, e=10 → result=68. Scan consumes 4 cycles before TO.
- e=0, x=77 → result=1. No STEP state is ever entered.
- x=238, e=255 → result=238. 8 iterations. With B given extra random latency, flags must still wait for both multipliers.
- start re-pulsed during STEP_W → ignored. The run completes with the correct result.
- resetn dropped during STEP_W → busy=0 and done=0 immediately. A subsequent x=5, e=3 run returns 125.
